// File: rtl/barrett_pkg.sv
// Shared types and width helpers for the sequential Barrett reducer.
package barrett_pkg;

    typedef enum logic [2:0] {
        IDLE,
        MUL_Q,
        MUL_QN,
        SUB,
        CORR1,
        CORR2,
        DONE
    } state_t;

    function automatic int prod_w(input int w);
        return 3 * w + 1;
    endfunction

    function automatic int q_w(input int w);
        return w + 1;
    endfunction

    function automatic int kw_f(input int w);
        return $clog2(w + 1);
    endfunction

    function automatic int step_w(input int w);
        return $clog2(w + 2);
    endfunction

    function automatic int latency(input int w);
        return 2 * w + 4;
    endfunction

endpackage

// File: rtl/shift_add_mul.sv
// LSB-first shift-add multiplier; the start cycle already performs the first step.
module shift_add_mul #(
    parameter int AW = 64,
    parameter int BW = 33,
    parameter int PW = 97,
    parameter int CW = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_i,
    input  logic [AW-1:0] a_i,
    input  logic [BW-1:0] b_i,
    input  logic [CW-1:0] steps_i,
    output logic          done_o,
    output logic [PW-1:0] product_o
);

    logic [PW-1:0] a_q, a_d;
    logic [PW-1:0] acc_q, acc_d;
    logic [BW-1:0] b_q, b_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        a_d   = a_q;
        b_d   = b_q;
        acc_d = acc_q;
        cnt_d = cnt_q;
        if (start_i) begin
            acc_d = b_i[0] ? PW'(a_i) : '0;
            a_d   = PW'(a_i) << 1;
            b_d   = b_i >> 1;
            cnt_d = steps_i - CW'(1);
        end else if (cnt_q != '0) begin
            if (b_q[0]) begin
                acc_d = acc_q + a_q;
            end
            a_d   = a_q << 1;
            b_d   = b_q >> 1;
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
            cnt_q <= '0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end

    assign done_o    = (cnt_q == '0);
    assign product_o = acc_q;

endmodule

// File: rtl/barrett_reduce_seq.sv
// Sequential Barrett reducer: remainder = numerator mod modulus, fixed 2W+4 cycle latency.
// Optional input range checking is enabled with `define BARRETT_RANGE_CHECK_EN.
module barrett_reduce_seq
    import barrett_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int KW    = $clog2(WIDTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2*WIDTH-1:0]   numerator,
    input  logic [WIDTH-1:0]     modulus,
    input  logic [WIDTH:0]       constant,
    input  logic [KW-1:0]        k,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     remainder,
    output logic                 err
);

    localparam int PW = prod_w(WIDTH);
    localparam int QW = q_w(WIDTH);
    localparam int XW = 2 * WIDTH;
    localparam int RW = 2 * WIDTH + 1;
    localparam int CW = step_w(WIDTH);

    state_t               state_q, state_d;
    logic [XW-1:0]        x_q, x_d;
    logic [WIDTH-1:0]     n_q, n_d;
    logic [KW-1:0]        k_q, k_d;
    logic [RW-1:0]        r_q, r_d;
    logic                 err_q, err_d;

    logic                 mul_start;
    logic [XW-1:0]        mul_a;
    logic [WIDTH:0]       mul_b;
    logic [CW-1:0]        mul_steps;
    logic                 mul_done;
    logic [PW-1:0]        mul_prod;
    logic [QW-1:0]        q;
    logic                 range_bad;

    shift_add_mul #(
        .AW(XW),
        .BW(WIDTH + 1),
        .PW(PW),
        .CW(CW)
    ) u_mul (
        .clk      (clk),
        .rst      (rst),
        .start_i  (mul_start),
        .a_i      (mul_a),
        .b_i      (mul_b),
        .steps_i  (mul_steps),
        .done_o   (mul_done),
        .product_o(mul_prod)
    );

    assign q = QW'(mul_prod >> {k_q, 1'b0});

`ifdef BARRETT_RANGE_CHECK_EN
    assign range_bad = (modulus == '0) || (k == '0) || (k > KW'(WIDTH)) ||
                       ((numerator >> {k, 1'b0}) != '0);
`else
    assign range_bad = 1'b0;
`endif

    // The q*n product is launched on the same edge that ends x*m, so q is taken
    // straight from the finished accumulator rather than from a register.
    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        n_d       = n_q;
        k_d       = k_q;
        r_d       = r_q;
        err_d     = err_q;
        mul_start = 1'b0;
        mul_a     = numerator;
        mul_b     = constant;
        mul_steps = CW'(WIDTH + 1);
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    x_d = numerator;
                    n_d = modulus;
                    k_d = k;
                    if (range_bad) begin
                        r_d     = '0;
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        err_d     = 1'b0;
                        mul_start = 1'b1;
                        state_d   = MUL_Q;
                    end
                end
            end
            MUL_Q: begin
                mul_a     = XW'(q);
                mul_b     = {1'b0, n_q};
                mul_steps = CW'(WIDTH);
                if (mul_done) begin
                    mul_start = 1'b1;
                    state_d   = MUL_QN;
                end
            end
            MUL_QN: begin
                if (mul_done) begin
                    state_d = SUB;
                end
            end
            SUB: begin
                r_d     = RW'(x_q) - mul_prod[RW-1:0];
                state_d = CORR1;
            end
            CORR1: begin
                if (r_q >= RW'(n_q)) begin
                    r_d = r_q - RW'(n_q);
                end
                state_d = CORR2;
            end
            CORR2: begin
                if (r_q >= RW'(n_q)) begin
                    r_d = r_q - RW'(n_q);
                end
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            x_q     <= '0;
            n_q     <= '0;
            k_q     <= '0;
            r_q     <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            n_q     <= n_d;
            k_q     <= k_d;
            r_q     <= r_d;
            err_q   <= err_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign remainder = r_q[WIDTH-1:0];
    assign err       = err_q;

endmodule

// File: tb/tb_barrett_reduce_seq.sv
// Scoreboard bench for barrett_reduce_seq at WIDTH=32; expectations from plain x % n arithmetic.
module tb_barrett_reduce_seq;

    localparam int W   = 32;
    localparam int KW  = $clog2(W + 1);
    localparam int LAT = 2 * W + 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [2*W-1:0]   numerator;
    logic [W-1:0]     modulus;
    logic [W:0]       constant;
    logic [KW-1:0]    k;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     remainder;
    logic             err;

    always #5 clk = ~clk;

    barrett_reduce_seq #(
        .WIDTH(W),
        .KW(KW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .numerator(numerator),
        .modulus  (modulus),
        .constant (constant),
        .k        (k),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .remainder(remainder),
        .err      (err)
    );

    typedef struct {
        logic [W-1:0] rem;
        logic         err;
        bit           chk_rem;
        longint       lat;
        longint       acc;
    } exp_t;

    exp_t     sb[$];
    exp_t     mon_e;
    int       checks = 0;
    int       errors = 0;
    longint   cyc = 0;
    longint   hs_cyc = -100;
    longint   last_acc = 0;
    int       xfers = 0;
    bit       seen = 0;
    logic [W-1:0] held_rem;
    logic     held_err;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: pops an expectation on each new result and checks hold stability.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && !seen) begin
                if (sb.size() == 0) begin
                    check("unexpected_output", longint'(sb.size()), 1);
                end else begin
                    mon_e = sb.pop_front();
                    if (mon_e.chk_rem) check("remainder", longint'(remainder), longint'(mon_e.rem));
                    check("err", longint'(err), longint'(mon_e.err));
                    check("latency", cyc - mon_e.acc, mon_e.lat);
                end
                seen     = 1;
                held_rem = remainder;
                held_err = err;
            end else if (out_valid && seen) begin
                check("hold_remainder", longint'(remainder), longint'(held_rem));
                check("hold_err", longint'(err), longint'(held_err));
            end
            if (out_valid && out_ready) begin
                xfers++;
                hs_cyc = cyc + 1;
                seen   = 0;
            end
        end
    end

    function automatic logic [W-1:0] ref_mod(input logic [2*W-1:0] x, input logic [W-1:0] n);
        logic [2*W-1:0] r;
        r = x % {{W{1'b0}}, n};
        return r[W-1:0];
    endfunction

    task automatic submit(input logic [2*W-1:0] x, input logic [W-1:0] n, input logic [W:0] m,
                          input int kk, input logic [W-1:0] rem, input logic e,
                          input bit chk, input longint lat);
        int   t;
        exp_t ent;
        t = 0;
        @(negedge clk);
        numerator = x;
        modulus   = n;
        constant  = m;
        k         = KW'(kk);
        in_valid  = 1'b1;
        while (!in_ready && t < 1000) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            check("accept_timeout", longint'(t), 0);
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            in_valid    = 1'b0;
            ent.rem     = rem;
            ent.err     = e;
            ent.chk_rem = chk;
            ent.lat     = lat;
            ent.acc     = cyc;
            sb.push_back(ent);
            last_acc = cyc;
        end
    endtask

    task automatic job(input logic [2*W-1:0] x, input logic [W-1:0] n, input int kk, input logic [W:0] m);
        submit(x, n, m, kk, ref_mod(x, n), 1'b0, 1'b1, LAT);
    endtask

    task automatic job_bad(input logic [2*W-1:0] x, input logic [W-1:0] n, input int kk, input logic [W:0] m);
`ifdef BARRETT_RANGE_CHECK_EN
        submit(x, n, m, kk, '0, 1'b1, 1'b1, 1);
`else
        submit(x, n, m, kk, '0, 1'b0, 1'b0, LAT);
`endif
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((sb.size() != 0 || out_valid) && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check("drain_timeout", longint'(sb.size()), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int   t;
        int   bad_cnt;
        int   x0;
        int   kk;
        int unsigned lo, hi;
        logic [W-1:0]   n;
        logic [2*W-1:0] nn, r64, x;
        logic [127:0]   four_k, mq;
        logic [W:0]     m;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        numerator = '0;
        modulus   = '0;
        constant  = '0;
        k         = '0;
        repeat (2) @(negedge clk);
        check("reset_in_ready", longint'(in_ready), 1);
        check("reset_out_valid", longint'(out_valid), 0);
        check("reset_remainder", longint'(remainder), 0);
        check("reset_err", longint'(err), 0);
        rst = 1'b0;

        // Directed cases, issued back to back.
        job(64'd200, 32'd13, 4, 33'd19);
        job(64'd255, 32'd13, 4, 33'd19);
        check("b2b_gap_1", last_acc - hs_cyc, 1);
        job(64'd0, 32'd13, 4, 33'd19);
        check("b2b_gap_2", last_acc - hs_cyc, 1);
        job(64'd484, 32'd23, 5, 33'd44);
        check("b2b_gap_3", last_acc - hs_cyc, 1);
        job(64'd200, 32'd13, 4, 33'd19);
        check("b2b_gap_4", last_acc - hs_cyc, 1);
        drain();

        // Back-pressure in DONE.
        out_ready = 1'b0;
        job(64'd200, 32'd13, 4, 33'd19);
        t = 0;
        while (!out_valid && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("bp_out_valid_rise", longint'(out_valid), 1);
        repeat (10) begin
            @(negedge clk);
            #1;
            check("bp_out_valid_held", longint'(out_valid), 1);
            check("bp_in_ready_low", longint'(in_ready), 0);
        end
        x0 = xfers;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("bp_single_transfer", longint'(xfers - x0), 1);
        check("bp_out_valid_drop", longint'(out_valid), 0);
        drain();

        // Reset in the middle of the q*n multiply.
        job(64'd200, 32'd13, 4, 33'd19);
        repeat (W + 6) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_in_ready", longint'(in_ready), 1);
        check("midrst_out_valid", longint'(out_valid), 0);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        bad_cnt = 0;
        repeat (LAT + 10) begin
            @(negedge clk);
            if (out_valid) bad_cnt++;
        end
        check("midrst_no_output", longint'(bad_cnt), 0);
        job(64'd200, 32'd13, 4, 33'd19);
        drain();

        // Out-of-range operands.
        job_bad(64'd256, 32'd13, 4, 33'd19);
        job_bad(64'd100, 32'd0, 4, 33'd0);
        drain();

        // Randomised jobs.
        for (int j = 0; j < 600; j++) begin
            kk = $urandom_range(2, W);
            lo = 32'(64'd1 << (kk - 1));
            hi = 32'((64'd1 << kk) - 64'd1);
            n  = $urandom_range(lo, hi);
            nn = {{W{1'b0}}, n} * {{W{1'b0}}, n};
            r64 = {$urandom(), $urandom()};
            x  = r64 % nn;
            four_k = 128'd1 << (2 * kk);
            mq = four_k / {96'd0, n};
            m  = mq[W:0];
            job(x, n, kk, m);
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
